ccr_branch_unit: RTL and testbench

- Owns the architectural condition-code register (CCR) for the 16-bit five-stage pipeline.
- Consumes the execute-stage ALU flags and resolves conditional jumps against the registered flags.
- Clears the tested flag when a conditional jump is taken.
- Saves the flags on interrupt entry and restores them on RTI; issues a registered PC redirect to fetch.

---
 rtl/ccr_branch_unit_pkg.sv | 23 ++
 rtl/ccr_branch_unit_branch_cond_eval.sv | 36 +++
 rtl/ccr_branch_unit.sv | 103 ++++++++++
 tb/tb_ccr_branch_unit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/ccr_branch_unit_pkg.sv
// Shared definitions for the condition-code register and branch resolution logic.
// Also imported by the ALU and hazard unit so flag bit positions stay consistent.
package ccr_branch_unit_pkg;

  localparam int FLAG_W = 3;

  localparam int Z_BIT = 0;
  localparam int N_BIT = 1;
  localparam int V_BIT = 2;

  typedef enum logic [1:0] {
    BR_JMP = 2'b00,
    BR_JZ  = 2'b01,
    BR_JN  = 2'b10,
    BR_JV  = 2'b11
  } br_cond_e;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_SAVED  = 1'b1
  } state_e;

endpackage

// File: rtl/ccr_branch_unit_branch_cond_eval.sv
// Combinational jump resolution against a flag vector: taken flag plus a one-hot
// mask of the flag a taken conditional jump consumes (zero for JMP or not-taken).
module branch_cond_eval
  import ccr_branch_unit_pkg::*;
(
  input  logic [FLAG_W-1:0] i_ccr,
  input  logic              i_br_valid,
  input  logic [1:0]        i_br_cond,
  output logic              o_taken,
  output logic [FLAG_W-1:0] o_clr_mask
);

  always_comb begin
    o_taken    = 1'b0;
    o_clr_mask = '0;
    if (i_br_valid) begin
      case (br_cond_e'(i_br_cond))
        BR_JMP: o_taken = 1'b1;
        BR_JZ: begin
          o_taken           = i_ccr[Z_BIT];
          o_clr_mask[Z_BIT] = i_ccr[Z_BIT];
        end
        BR_JN: begin
          o_taken           = i_ccr[N_BIT];
          o_clr_mask[N_BIT] = i_ccr[N_BIT];
        end
        BR_JV: begin
          o_taken           = i_ccr[V_BIT];
          o_clr_mask[V_BIT] = i_ccr[V_BIT];
        end
        default: o_taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ccr_branch_unit.sv
// Architectural condition-code register with interrupt save/restore and a
// registered PC redirect for jumps resolved in EX.
module ccr_branch_unit
  import ccr_branch_unit_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall,
  input  logic [FLAG_W-1:0] i_alu_ccr,
  input  logic              i_flag_we,
  input  logic              i_br_valid,
  input  logic [1:0]        i_br_cond,
  input  logic [ADDR_W-1:0] i_br_target,
  input  logic              i_int_req,
  input  logic              i_rti,
  output logic [FLAG_W-1:0] o_ccr,
  output logic              o_pc_redirect,
  output logic [ADDR_W-1:0] o_pc_target,
  output logic              o_shadow_valid,
  output logic              o_nest_err
);

  state_e              r_state;
  logic [FLAG_W-1:0]   r_ccr;
  logic [FLAG_W-1:0]   r_shadow;
  logic                r_pc_redirect;
  logic [ADDR_W-1:0]   r_pc_target;
  logic                r_nest_err;

  logic                w_taken;
  logic [FLAG_W-1:0]   w_clr_mask;
  logic [FLAG_W-1:0]   w_next_ccr;

  // Resolution always looks at the registered flags, never this cycle's ALU result.
  branch_cond_eval u_cond_eval (
    .i_ccr      (r_ccr),
    .i_br_valid (i_br_valid),
    .i_br_cond  (i_br_cond),
    .o_taken    (w_taken),
    .o_clr_mask (w_clr_mask)
  );

  always_comb begin
    w_next_ccr = r_ccr;
    if (i_rti && (r_state == ST_SAVED)) begin
      w_next_ccr = r_shadow;
    end else begin
      w_next_ccr = (i_flag_we ? i_alu_ccr : r_ccr) & ~w_clr_mask;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_NORMAL;
      r_ccr         <= '0;
      r_shadow      <= '0;
      r_pc_redirect <= 1'b0;
      r_pc_target   <= '0;
      r_nest_err    <= 1'b0;
    end else if (i_stall) begin
      r_pc_redirect <= 1'b0;
    end else begin
      r_ccr         <= w_next_ccr;
      r_pc_redirect <= w_taken;
      if (w_taken) begin
        r_pc_target <= i_br_target;
      end
      case (r_state)
        ST_NORMAL: begin
          if (i_int_req) begin
            r_shadow <= w_next_ccr;
            r_state  <= ST_SAVED;
          end
          if (i_rti) begin
            r_nest_err <= 1'b1;
          end
        end
        ST_SAVED: begin
          // An interrupt arriving with RTI re-saves the restored flags and stays SAVED.
          if (i_rti) begin
            if (i_int_req) begin
              r_shadow <= w_next_ccr;
            end else begin
              r_state <= ST_NORMAL;
            end
          end else if (i_int_req) begin
            r_nest_err <= 1'b1;
          end
        end
        default: r_state <= ST_NORMAL;
      endcase
    end
  end

  assign o_ccr          = r_ccr;
  assign o_pc_redirect  = r_pc_redirect;
  assign o_pc_target    = r_pc_target;
  assign o_shadow_valid = (r_state == ST_SAVED);
  assign o_nest_err     = r_nest_err;

endmodule

// File: tb/tb_ccr_branch_unit.sv
// Directed scoreboard bench for ccr_branch_unit: each driven cycle queues the
// expected post-edge outputs, and a monitor compares them after every clock edge.
module tb_ccr_branch_unit;
  import ccr_branch_unit_pkg::*;

  localparam int ADDR_W = 16;
  localparam int EXP_W  = FLAG_W + 1 + ADDR_W + 1 + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              stall = 1'b0;
  logic [FLAG_W-1:0] alu_ccr = '0;
  logic              flag_we = 1'b0;
  logic              br_valid = 1'b0;
  logic [1:0]        br_cond = 2'b00;
  logic [ADDR_W-1:0] br_target = '0;
  logic              int_req = 1'b0;
  logic              rti = 1'b0;
  logic [FLAG_W-1:0] ccr;
  logic              pc_redirect;
  logic [ADDR_W-1:0] pc_target;
  logic              shadow_valid;
  logic              nest_err;

  logic [EXP_W-1:0]  expQ[$];
  string             nameQ[$];
  int                checks = 0;
  int                errors = 0;

  always #5 clk = ~clk;

  ccr_branch_unit #(.ADDR_W(ADDR_W)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_stall        (stall),
    .i_alu_ccr      (alu_ccr),
    .i_flag_we      (flag_we),
    .i_br_valid     (br_valid),
    .i_br_cond      (br_cond),
    .i_br_target    (br_target),
    .i_int_req      (int_req),
    .i_rti          (rti),
    .o_ccr          (ccr),
    .o_pc_redirect  (pc_redirect),
    .o_pc_target    (pc_target),
    .o_shadow_valid (shadow_valid),
    .o_nest_err     (nest_err)
  );

  task automatic checkOutput(input logic [EXP_W-1:0] expv, input string nm);
    logic [EXP_W-1:0] act;
    act = {ccr, pc_redirect, pc_target, shadow_valid, nest_err};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got ccr=%b redir=%b tgt=%h sv=%b nerr=%b, expected ccr=%b redir=%b tgt=%h sv=%b nerr=%b",
               nm, act[EXP_W-1 -: FLAG_W], act[ADDR_W+2], act[ADDR_W+1:2], act[1], act[0],
               expv[EXP_W-1 -: FLAG_W], expv[ADDR_W+2], expv[ADDR_W+1:2], expv[1], expv[0]);
    end
  endtask

  // Monitor: outputs settle just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) begin
      checkOutput(expQ.pop_front(), nameQ.pop_front());
    end
  end

  task automatic applyStimulus(
    input logic r, input logic st, input logic fwe, input logic [2:0] alu,
    input logic bv, input logic [1:0] cond, input logic [15:0] tgt,
    input logic ir, input logic rt,
    input logic [2:0] eCcr, input logic eRed, input logic [15:0] eTgt,
    input logic eSv, input logic eNerr, input string nm);
    @(negedge clk);
    rst       = r;
    stall     = st;
    flag_we   = fwe;
    alu_ccr   = alu;
    br_valid  = bv;
    br_cond   = cond;
    br_target = tgt;
    int_req   = ir;
    rti       = rt;
    expQ.push_back({eCcr, eRed, eTgt, eSv, eNerr});
    nameQ.push_back(nm);
  endtask

  initial begin
    //            rst st fwe alu    bv cond   target     ir rti  | ccr    red tgt        sv ne
    applyStimulus(1, 0, 0, 3'b000, 0, 2'b00, 16'h0000, 0, 0,   3'b000, 0, 16'h0000, 0, 0, "reset");
    applyStimulus(0, 0, 1, 3'b001, 0, 2'b00, 16'h0000, 0, 0,   3'b001, 0, 16'h0000, 0, 0, "write_z");
    applyStimulus(0, 0, 0, 3'b000, 1, 2'b01, 16'h0040, 0, 0,   3'b000, 1, 16'h0040, 0, 0, "jz_taken");
    applyStimulus(0, 0, 1, 3'b010, 0, 2'b00, 16'h0000, 0, 0,   3'b010, 0, 16'h0040, 0, 0, "write_n");
    applyStimulus(0, 0, 0, 3'b000, 1, 2'b01, 16'h0100, 0, 0,   3'b010, 0, 16'h0040, 0, 0, "jz_not_taken");
    applyStimulus(0, 0, 0, 3'b000, 1, 2'b00, 16'h0200, 0, 0,   3'b010, 1, 16'h0200, 0, 0, "jmp_always");
    applyStimulus(0, 0, 1, 3'b000, 0, 2'b00, 16'h0000, 0, 0,   3'b000, 0, 16'h0200, 0, 0, "clear_flags");
    applyStimulus(0, 0, 1, 3'b100, 1, 2'b11, 16'h0300, 0, 0,   3'b100, 0, 16'h0200, 0, 0, "jv_uses_old_ccr");
    applyStimulus(0, 0, 0, 3'b000, 1, 2'b11, 16'h0304, 0, 0,   3'b000, 1, 16'h0304, 0, 0, "jv_taken");
    applyStimulus(0, 0, 1, 3'b011, 0, 2'b00, 16'h0000, 0, 0,   3'b011, 0, 16'h0304, 0, 0, "write_011");
    applyStimulus(0, 0, 0, 3'b000, 0, 2'b00, 16'h0000, 1, 0,   3'b011, 0, 16'h0304, 1, 0, "int_entry");
    applyStimulus(0, 0, 1, 3'b100, 0, 2'b00, 16'h0000, 0, 0,   3'b100, 0, 16'h0304, 1, 0, "isr_write");
    applyStimulus(0, 0, 0, 3'b000, 0, 2'b00, 16'h0000, 0, 1,   3'b011, 0, 16'h0304, 0, 0, "rti_restore");
    applyStimulus(0, 1, 1, 3'b111, 1, 2'b00, 16'h0400, 0, 0,   3'b011, 0, 16'h0304, 0, 0, "stall_hold");
    applyStimulus(0, 0, 1, 3'b111, 1, 2'b00, 16'h0400, 0, 0,   3'b111, 1, 16'h0400, 0, 0, "stall_release");
    applyStimulus(0, 0, 0, 3'b000, 0, 2'b00, 16'h0000, 0, 0,   3'b111, 0, 16'h0400, 0, 0, "redirect_once");
    applyStimulus(0, 0, 0, 3'b000, 0, 2'b00, 16'h0000, 0, 1,   3'b111, 0, 16'h0400, 0, 1, "rti_in_normal");
    applyStimulus(0, 0, 1, 3'b001, 0, 2'b00, 16'h0000, 0, 0,   3'b001, 0, 16'h0400, 0, 1, "nest_err_sticky");
    applyStimulus(0, 0, 0, 3'b000, 0, 2'b00, 16'h0000, 1, 0,   3'b001, 0, 16'h0400, 1, 1, "int_save_001");
    applyStimulus(0, 0, 1, 3'b110, 0, 2'b00, 16'h0000, 1, 0,   3'b110, 0, 16'h0400, 1, 1, "int_while_saved");
    applyStimulus(0, 0, 0, 3'b000, 0, 2'b00, 16'h0000, 0, 1,   3'b001, 0, 16'h0400, 0, 1, "shadow_kept_first");
    applyStimulus(0, 0, 0, 3'b000, 0, 2'b00, 16'h0000, 1, 0,   3'b001, 0, 16'h0400, 1, 1, "int_again");
    applyStimulus(0, 0, 1, 3'b010, 0, 2'b00, 16'h0000, 0, 0,   3'b010, 0, 16'h0400, 1, 1, "isr_write_010");
    applyStimulus(0, 0, 1, 3'b111, 0, 2'b00, 16'h0000, 1, 1,   3'b001, 0, 16'h0400, 1, 1, "rti_int_back2back");
    applyStimulus(0, 0, 0, 3'b000, 0, 2'b00, 16'h0000, 0, 1,   3'b001, 0, 16'h0400, 0, 1, "rti_after_b2b");
    applyStimulus(0, 0, 1, 3'b101, 1, 2'b01, 16'h0500, 1, 0,   3'b100, 1, 16'h0500, 1, 1, "int_with_write_clear");
    applyStimulus(0, 0, 1, 3'b011, 0, 2'b00, 16'h0000, 0, 0,   3'b011, 0, 16'h0500, 1, 1, "isr_write_011");
    applyStimulus(0, 0, 0, 3'b000, 0, 2'b00, 16'h0000, 0, 1,   3'b100, 0, 16'h0500, 0, 1, "rti_shadow_cleared");
    applyStimulus(0, 0, 0, 3'b000, 0, 2'b00, 16'h0000, 1, 0,   3'b100, 0, 16'h0500, 1, 1, "int_before_reset");
    applyStimulus(1, 0, 1, 3'b111, 1, 2'b00, 16'h0700, 1, 1,   3'b000, 0, 16'h0000, 0, 0, "reset_in_saved");
    applyStimulus(0, 0, 0, 3'b000, 0, 2'b00, 16'h0000, 0, 1,   3'b000, 0, 16'h0000, 0, 1, "normal_after_reset");
    applyStimulus(0, 0, 1, 3'b010, 0, 2'b00, 16'h0000, 0, 0,   3'b010, 0, 16'h0000, 0, 1, "write_n_again");
    applyStimulus(0, 0, 0, 3'b000, 1, 2'b10, 16'h0600, 0, 0,   3'b000, 1, 16'h0600, 0, 1, "jn_taken");
    applyStimulus(0, 0, 0, 3'b000, 1, 2'b10, 16'h0610, 0, 0,   3'b000, 0, 16'h0600, 0, 1, "jn_not_taken");
    applyStimulus(0, 0, 0, 3'b000, 0, 2'b00, 16'h0000, 0, 0,   3'b000, 0, 16'h0600, 0, 1, "idle");

    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(posedge clk);
    end
    #2;
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
